// File: rtl/vit_act_pkg.sv
// Shared types and constants for the ViT activation requantization divider.
package vit_act_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StFix,
    StDone
  } state_e;

  localparam int QUOT_MAX = 32767;
  localparam int QUOT_MIN = -32768;

  // Bits needed to hold values 0 .. v-1.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 31; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/vit_act_div_step.sv
// One radix-2 restoring division iteration: shift in a dividend bit, compare, subtract.
module vit_act_div_step #(
  parameter int unsigned DIVISOR_W = 8
) (
  input  logic [DIVISOR_W:0]   rem_i,
  input  logic                 bit_i,
  input  logic [DIVISOR_W-1:0] divisor_i,
  output logic [DIVISOR_W:0]   rem_o,
  output logic                 q_o
);

  logic [DIVISOR_W+1:0] shifted;
  logic [DIVISOR_W+1:0] div_ext;

  assign shifted = {rem_i, bit_i};
  assign div_ext = {2'b00, divisor_i};

  always_comb begin
    q_o   = (shifted >= div_ext);
    // The running remainder stays below the divisor, so the top bit can be dropped.
    rem_o = (DIVISOR_W + 1)'(q_o ? (shifted - div_ext) : shifted);
  end

endmodule

// File: rtl/vit_act_div_24s_8ns_16.sv
// Iterative signed/unsigned divider with saturated signed quotient.
// Optional build macro: VIT_ACT_DIV_ROUND_NEAREST_EN (round half away from zero).
module vit_act_div_24s_8ns_16
  import vit_act_pkg::*;
#(
  parameter int unsigned DIVIDEND_W = 24,
  parameter int unsigned DIVISOR_W  = 8,
  parameter int unsigned QUOT_W     = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [QUOT_W-1:0]     quot,
  output logic [DIVISOR_W:0]    rem,
  output logic                  ovf,
  output logic                  dz
);

  localparam int unsigned CntW = clog2(DIVIDEND_W + 1);
  localparam logic [DIVIDEND_W:0] MaxMag =
    (DIVIDEND_W + 1)'((64'd1 << (QUOT_W - 1)) - 64'd1);
  localparam logic [DIVIDEND_W:0] MinMag = MaxMag + (DIVIDEND_W + 1)'(1);
  localparam logic [QUOT_W-1:0] QuotMax = {1'b0, {(QUOT_W - 1){1'b1}}};
  localparam logic [QUOT_W-1:0] QuotMin = {1'b1, {(QUOT_W - 1){1'b0}}};

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [DIVIDEND_W-1:0] mag_q, mag_d;
  logic [DIVISOR_W:0]    prem_q, prem_d;
  logic                  neg_q, neg_d;
  logic [DIVISOR_W-1:0]  div_q, div_d;
  logic [QUOT_W-1:0]     quot_q, quot_d;
  logic [DIVISOR_W:0]    rem_q, rem_d;
  logic                  ovf_q, ovf_d;
  logic                  dz_q, dz_d;

  logic [DIVISOR_W:0]    step_rem;
  logic                  step_q;
  logic [DIVIDEND_W:0]   qmag;

  vit_act_div_step #(
    .DIVISOR_W(DIVISOR_W)
  ) u_step (
    .rem_i    (prem_q),
    .bit_i    (mag_q[DIVIDEND_W-1]),
    .divisor_i(div_q),
    .rem_o    (step_rem),
    .q_o      (step_q)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mag_d   = mag_q;
    prem_d  = prem_q;
    neg_d   = neg_q;
    div_d   = div_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    ovf_d   = ovf_q;
    dz_d    = dz_q;
    qmag    = {1'b0, mag_q};

`ifdef VIT_ACT_DIV_ROUND_NEAREST_EN
    if ({prem_q, 1'b0} >= {2'b00, div_q}) qmag = qmag + (DIVIDEND_W + 1)'(1);
`endif

    case (state_q)
      StIdle: begin
        if (in_valid) begin
          neg_d   = dividend[DIVIDEND_W-1];
          // Magnitude is unsigned so that |-2^(W-1)| fits.
          mag_d   = dividend[DIVIDEND_W-1] ? -dividend : dividend;
          div_d   = divisor;
          prem_d  = '0;
          cnt_d   = '0;
          state_d = StCalc;
        end
      end
      StCalc: begin
        prem_d = step_rem;
        mag_d  = {mag_q[DIVIDEND_W-2:0], step_q};
        cnt_d  = cnt_q + CntW'(1);
        if (cnt_q == CntW'(DIVIDEND_W - 1)) state_d = StFix;
      end
      StFix: begin
        if (div_q == '0) begin
          quot_d = neg_q ? QuotMin : QuotMax;
          rem_d  = '0;
          ovf_d  = 1'b0;
          dz_d   = 1'b1;
        end else begin
          dz_d  = 1'b0;
          rem_d = neg_q ? -prem_q : prem_q;
          if (!neg_q && (qmag > MaxMag)) begin
            quot_d = QuotMax;
            ovf_d  = 1'b1;
          end else if (neg_q && (qmag > MinMag)) begin
            quot_d = QuotMin;
            ovf_d  = 1'b1;
          end else begin
            quot_d = neg_q ? -qmag[QUOT_W-1:0] : qmag[QUOT_W-1:0];
            ovf_d  = 1'b0;
          end
        end
        state_d = StDone;
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      mag_q   <= '0;
      prem_q  <= '0;
      neg_q   <= 1'b0;
      div_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      ovf_q   <= 1'b0;
      dz_q    <= 1'b0;
    end else if (ce) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mag_q   <= mag_d;
      prem_q  <= prem_d;
      neg_q   <= neg_d;
      div_q   <= div_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      ovf_q   <= ovf_d;
      dz_q    <= dz_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign quot      = quot_q;
  assign rem       = rem_q;
  assign ovf       = ovf_q;
  assign dz        = dz_q;

endmodule

// File: tb/tb_vit_act_div_24s_8ns_16.sv
// Bench for vit_act_div_24s_8ns_16: vector table, scoreboard queue, timing corner cases.
module tb_vit_act_div_24s_8ns_16;

  logic        clk;
  logic        reset;
  logic        ce;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] dividend;
  logic [7:0]  divisor;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] quot;
  logic [8:0]  rem;
  logic        ovf;
  logic        dz;

  vit_act_div_24s_8ns_16 dut (
    .clk      (clk),
    .reset    (reset),
    .ce       (ce),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .dividend (dividend),
    .divisor  (divisor),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .quot     (quot),
    .rem      (rem),
    .ovf      (ovf),
    .dz       (dz)
  );

  typedef struct {
    int dvd;
    int dvs;
    int q_t;
    int q_r;
    int rem;
    int ovf_t;
    int ovf_r;
    int dz;
  } vec_t;

  localparam int NumVec = 18;
  // Edges from the accept edge to the first edge after which out_valid is seen (cycle 26).
  localparam int Lat = 25;

  vec_t tbl[NumVec];
  vec_t sb[$];
  int   checks;
  int   failures;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout act=running req=finished");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0d req=%0d", name, act, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_in_ready"}, int'(in_ready), 1);
    chk({tag, "_out_valid"}, int'(out_valid), 0);
    chk({tag, "_quot"}, int'($signed(quot)), 0);
    chk({tag, "_rem"}, int'($signed(rem)), 0);
    chk({tag, "_ovf"}, int'(ovf), 0);
    chk({tag, "_dz"}, int'(dz), 0);
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    chk({tag, "_wait_in_ready"}, int'(in_ready), 1);
  endtask

  // ce_at < 0 disables the clock-enable gap; hold = cycles out_ready stays low in DONE.
  task automatic run_op(input string tag, input vec_t v, input int ce_at, input int ce_len,
                        input int hold, input int exp_lat);
    int   lat;
    int   exp_q;
    int   exp_ovf;
    vec_t e;
    wait_ready(tag);
    out_ready = (hold == 0);
    in_valid  = 1'b1;
    dividend  = v.dvd[23:0];
    divisor   = v.dvs[7:0];
    tick();
    in_valid  = 1'b0;
    dividend  = 24'h5a5a5a;
    divisor   = 8'h33;
    sb.push_back(v);
    lat = 0;
    while (!out_valid && lat < 200) begin
      if (lat == ce_at) ce = 1'b0;
      if (lat == ce_at + ce_len) ce = 1'b1;
      tick();
      lat++;
    end
    ce = 1'b1;
    chk({tag, "_out_valid"}, int'(out_valid), 1);
    chk({tag, "_latency"}, lat, exp_lat);
    e = sb.pop_front();
`ifdef VIT_ACT_DIV_ROUND_NEAREST_EN
    exp_q   = e.q_r;
    exp_ovf = e.ovf_r;
`else
    exp_q   = e.q_t;
    exp_ovf = e.ovf_t;
`endif
    chk({tag, "_quot"}, int'($signed(quot)), exp_q);
    chk({tag, "_rem"}, int'($signed(rem)), e.rem);
    chk({tag, "_ovf"}, int'(ovf), exp_ovf);
    chk({tag, "_dz"}, int'(dz), e.dz);
    chk({tag, "_busy"}, int'(in_ready), 0);
    for (int i = 0; i < hold; i++) begin
      tick();
      chk($sformatf("%s_hold%0d_valid", tag, i), int'(out_valid), 1);
      chk($sformatf("%s_hold%0d_quot", tag, i), int'($signed(quot)), exp_q);
      chk($sformatf("%s_hold%0d_rem", tag, i), int'($signed(rem)), e.rem);
      chk($sformatf("%s_hold%0d_in_ready", tag, i), int'(in_ready), 0);
    end
    out_ready = 1'b1;
    tick();
    chk({tag, "_valid_cleared"}, int'(out_valid), 0);
    chk({tag, "_ready_after"}, int'(in_ready), 1);
  endtask

  initial begin
    int   seen;
    vec_t v;
    checks    = 0;
    failures  = 0;
    reset     = 1'b0;
    ce        = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    dividend  = '0;
    divisor   = '0;

    //        dvd       dvs  q_trunc  q_round   rem  ovf_t ovf_r dz
    tbl[0]  = '{1000,     7,   142,     143,     6,   0, 0, 0};
    tbl[1]  = '{-1000,    7,  -142,    -143,    -6,   0, 0, 0};
    tbl[2]  = '{8388607,  1,  32767,   32767,    0,   1, 1, 0};
    tbl[3]  = '{-8388608, 1, -32768,  -32768,    0,   1, 1, 0};
    tbl[4]  = '{32767,    1,  32767,   32767,    0,   0, 0, 0};
    tbl[5]  = '{5,        0,  32767,   32767,    0,   0, 0, 1};
    tbl[6]  = '{-5,       0, -32768,  -32768,    0,   0, 0, 1};
    tbl[7]  = '{100,      3,    33,      33,     1,   0, 0, 0};
    tbl[8]  = '{-32768,   1, -32768,  -32768,    0,   0, 0, 0};
    tbl[9]  = '{32768,    1,  32767,   32767,    0,   1, 1, 0};
    tbl[10] = '{255,    255,     1,       1,     0,   0, 0, 0};
    tbl[11] = '{-7,       2,    -3,      -4,    -1,   0, 0, 0};
    tbl[12] = '{8388607, 255, 32767,   32767,  127,   1, 1, 0};
    tbl[13] = '{65535,    2,  32767,   32767,    1,   0, 1, 0};
    tbl[14] = '{-65535,   2, -32767,  -32768,   -1,   0, 0, 0};
    tbl[15] = '{200,    255,     0,       1,   200,   0, 0, 0};
    tbl[16] = '{0,        9,     0,       0,     0,   0, 0, 0};
    tbl[17] = '{-1,       1,    -1,      -1,     0,   0, 0, 0};

    tick();
    tick();
    reset = 1'b1;
    chk_idle_outputs("reset");

    for (int i = 0; i < NumVec; i++) begin
      run_op($sformatf("vec%0d", i), tbl[i], -1, 0, 0, Lat);
    end

    run_op("backpressure", tbl[0], -1, 0, 10, Lat);
    run_op("ce_gap", tbl[1], 5, 5, 0, Lat + 5);

    // Abort an operation with reset 10 cycles into CALC; outputs currently hold -142.
    wait_ready("abort");
    in_valid = 1'b1;
    dividend = 24'd1000;
    divisor  = 8'd7;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk_idle_outputs("abort");
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (out_valid) seen++;
    end
    chk("abort_no_result", seen, 0);

    v = tbl[7];
    run_op("after_abort", v, -1, 0, 0, Lat);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
